// File: rtl/ald_cycle_sequencer_if.sv
// ald_cycle_sequencer_if: board-side bundle for the ALD cycle sequencer.
//   master : drives tick/start/stop/sensors/presets, observes actuators and status
//   slave  : the sequencer; consumes controls/presets, drives actuators and status
//   Signals: tick, start, stop, temp_ok, pressure_ok, pulse_pre, purge_pre,
//            gap_pre, cycles_pre -> valve, vac_valve, vac_pump, heater, busy,
//            done, fault, cycle_cnt, ch_idx, state
interface ald_cycle_sequencer_if #(
  parameter int unsigned N_CH = 2,
  parameter int unsigned TW   = 32,
  parameter int unsigned CW   = 16
);
  localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                 tick;
  logic                 start;
  logic                 stop;
  logic                 temp_ok;
  logic                 pressure_ok;
  logic [N_CH*TW-1:0]   pulse_pre;
  logic [N_CH*TW-1:0]   purge_pre;
  logic [TW-1:0]        gap_pre;
  logic [CW-1:0]        cycles_pre;

  logic [N_CH-1:0]      valve;
  logic                 vac_valve;
  logic                 vac_pump;
  logic                 heater;
  logic                 busy;
  logic                 done;
  logic                 fault;
  logic [CW-1:0]        cycle_cnt;
  logic [CHW-1:0]       ch_idx;
  logic [2:0]           state;

  modport master (
    output tick, start, stop, temp_ok, pressure_ok,
    output pulse_pre, purge_pre, gap_pre, cycles_pre,
    input  valve, vac_valve, vac_pump, heater, busy, done, fault,
    input  cycle_cnt, ch_idx, state
  );

  modport slave (
    input  tick, start, stop, temp_ok, pressure_ok,
    input  pulse_pre, purge_pre, gap_pre, cycles_pre,
    output valve, vac_valve, vac_pump, heater, busy, done, fault,
    output cycle_cnt, ch_idx, state
  );
endinterface

// File: rtl/ald_cycle_sequencer.sv
// ald_cycle_sequencer: ALD cycle sequencer. Pump-down, thermal stabilisation,
// then per cycle each of N_CH precursor channels runs pulse -> gap -> purge,
// repeated for the snapshotted cycle count. All durations are in ticks.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : ald_cycle_sequencer_if.slave (controls, sensors, presets in;
//          actuators, status, cycle_cnt, ch_idx, state out; all registered)
// Optional feature (macro ALD_PRESSURE_INTERLOCK_EN): in PULSE, pressure_ok=0
// closes the valve and freezes the timer until pressure returns. Without the
// macro pressure_ok is ignored.
module ald_cycle_sequencer #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned TW     = 32,
  parameter int unsigned CW     = 16,
  parameter int unsigned PUMP_T = 200,
  parameter int unsigned STAB_T = 10000
) (
  input  logic               clk,
  input  logic               rst,
  ald_cycle_sequencer_if.slave bus
);
  localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PUMP  = 3'd1,
    S_STAB  = 3'd2,
    S_PULSE = 3'd3,
    S_GAP   = 3'd4,
    S_PURGE = 3'd5,
    S_DONE  = 3'd6,
    S_FAULT = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   acc_q, acc_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            fault_q, fault_d;
  logic            start_prev_q;

  logic [TW-1:0]   pulse_q [N_CH];
  logic [TW-1:0]   purge_q [N_CH];
  logic [TW-1:0]   gap_q;
  logic [CW-1:0]   cycles_q;

  logic [N_CH-1:0] valve_q, valve_d;
  logic            vac_valve_q, vac_valve_d;
  logic            vac_pump_q, vac_pump_d;
  logic            heater_q, heater_d;
  logic            busy_q, busy_d;

  logic            snap_en;
  logic            start_edge_c;
  logic            press_ok_c;
  logic [CW-1:0]   cnt_inc_c;

  assign start_edge_c = bus.start & ~start_prev_q;

`ifdef ALD_PRESSURE_INTERLOCK_EN
  assign press_ok_c = bus.pressure_ok;
`else
  assign press_ok_c = 1'b1;
`endif

  // Completed-cycle count never runs past the requested cycle count
  assign cnt_inc_c = (cnt_q < cycles_q) ? cnt_q + CW'(1) : cnt_q;

  // State, timer, counters and snapshot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      ch_q         <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      start_prev_q <= 1'b0;
      gap_q        <= '0;
      cycles_q     <= '0;
      for (int k = 0; k < N_CH; k++) begin
        pulse_q[k] <= '0;
        purge_q[k] <= '0;
      end
      valve_q      <= '0;
      vac_valve_q  <= 1'b0;
      vac_pump_q   <= 1'b0;
      heater_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      start_prev_q <= bus.start;
      if (snap_en) begin
        gap_q    <= bus.gap_pre;
        cycles_q <= bus.cycles_pre;
        for (int k = 0; k < N_CH; k++) begin
          pulse_q[k] <= bus.pulse_pre[k*TW +: TW];
          purge_q[k] <= bus.purge_pre[k*TW +: TW];
        end
      end
      valve_q      <= valve_d;
      vac_valve_q  <= vac_valve_d;
      vac_pump_q   <= vac_pump_d;
      heater_q     <= heater_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state, timer and counter logic; outputs decoded from next state
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    fault_d     = fault_q;
    snap_en     = 1'b0;
    valve_d     = '0;
    vac_valve_d = 1'b0;
    vac_pump_d  = 1'b0;
    heater_d    = 1'b0;
    busy_d      = 1'b0;

    if (bus.stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_edge_c) begin
            snap_en = 1'b1;
            ch_d    = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            fault_d = 1'b0;
            state_d = (bus.cycles_pre == '0) ? S_DONE : S_PUMP;
          end
        end
        S_PUMP: begin
          if (acc_q >= TW'(PUMP_T))  state_d = S_STAB;
          else if (bus.tick)         acc_d   = acc_q + TW'(1);
        end
        S_STAB: begin
          // Stabilisation needs STAB_T consecutive in-range ticks
          if (acc_q >= TW'(STAB_T))  state_d = S_PULSE;
          else if (!bus.temp_ok)     acc_d   = '0;
          else if (bus.tick)         acc_d   = acc_q + TW'(1);
        end
        S_PULSE: begin
          if (!bus.temp_ok)                      state_d = S_FAULT;
          else if (acc_q >= pulse_q[ch_q])       state_d = S_GAP;
          else if (bus.tick && press_ok_c)       acc_d   = acc_q + TW'(1);
        end
        S_GAP: begin
          if (!bus.temp_ok)                      state_d = S_FAULT;
          else if (acc_q >= gap_q)               state_d = S_PURGE;
          else if (bus.tick)                     acc_d   = acc_q + TW'(1);
        end
        S_PURGE: begin
          if (!bus.temp_ok) begin
            state_d = S_FAULT;
          end else if (acc_q >= purge_q[ch_q]) begin
            if (ch_q < CHW'(N_CH - 1)) begin
              ch_d    = ch_q + CHW'(1);
              state_d = S_PULSE;
            end else begin
              ch_d    = '0;
              cnt_d   = cnt_inc_c;
              state_d = (cnt_inc_c == cycles_q) ? S_DONE : S_PULSE;
            end
          end else if (bus.tick) begin
            acc_d = acc_q + TW'(1);
          end
        end
        S_FAULT: ;
        default: state_d = S_IDLE;
      endcase
    end

    // Timer restarts on every state entry
    if (state_d != state_q) acc_d = '0;
    if (state_d == S_DONE)  done_d  = 1'b1;
    if (state_d == S_FAULT) fault_d = 1'b1;

    case (state_d)
      S_PUMP: begin
        vac_pump_d  = 1'b1;
        vac_valve_d = 1'b1;
        heater_d    = 1'b1;
      end
      S_STAB, S_GAP: begin
        vac_pump_d = 1'b1;
        heater_d   = 1'b1;
      end
      S_PULSE: begin
        valve_d    = press_ok_c ? (N_CH'(1) << ch_d) : '0;
        vac_pump_d = 1'b1;
        heater_d   = 1'b1;
      end
      S_PURGE: begin
        vac_valve_d = 1'b1;
        vac_pump_d  = 1'b1;
        heater_d    = 1'b1;
      end
      S_DONE, S_FAULT: vac_pump_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  assign bus.valve     = valve_q;
  assign bus.vac_valve = vac_valve_q;
  assign bus.vac_pump  = vac_pump_q;
  assign bus.heater    = heater_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.cycle_cnt = cnt_q;
  assign bus.ch_idx    = ch_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_ald_cycle_sequencer.sv
// Scoreboard bench for ald_cycle_sequencer: a run model expands presets into
// the expected sequence of state segments (state, channel, cycle, tick length);
// a monitor pops one segment per observed state change and checks outputs on
// entry and tick length on exit.
`timescale 1ns/1ps
module tb_ald_cycle_sequencer;
  localparam int unsigned N_CH = 2, TW = 32, CW = 16, PUMP_T = 4, STAB_T = 3;

  typedef struct {
    int st; int ch; int cnt; int dur; int open; int dn; int ft;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  ald_cycle_sequencer_if #(.N_CH(N_CH), .TW(TW), .CW(CW)) bus ();

  ald_cycle_sequencer #(.N_CH(N_CH), .TW(TW), .CW(CW), .PUMP_T(PUMP_T), .STAB_T(STAB_T))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #10 clk = ~clk;

  int   checks = 0;
  int   passed = 0;
  rec_t q[$];
  rec_t cur;
  bit   abort_seg = 1'b0;
  int   tick_edges = 0;
  int   tdiv = 0;
  int   cfg_pulse [N_CH];
  int   cfg_purge [N_CH];
  int   cfg_gap, cfg_cyc;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL timeout %s (t=%0t)", name, $time);
  endtask

  // One tick strobe every 4 clocks; tick_edges counts ticks seen at posedges
  always @(posedge clk) begin
    if (bus.tick) tick_edges++;
    #1;
    tdiv     = (tdiv + 1) % 4;
    bus.tick = (tdiv == 0);
  end

  // Expected actuator pattern of a state
  function automatic void exp_out(input int st, input int ch, output int v, output int vv,
                                  output int vp, output int ht, output int bz);
    v = 0; vv = 0; vp = 0; ht = 0;
    bz = (st != 0 && st != 6) ? 1 : 0;
    case (st)
      1:    begin vp = 1; vv = 1; ht = 1; end
      2, 4: begin vp = 1; ht = 1; end
      3:    begin v = 1 << ch; vp = 1; ht = 1; end
      5:    begin vv = 1; vp = 1; ht = 1; end
      6, 7: vp = 1;
      default: ;
    endcase
  endfunction

  // Expand the current configuration into the expected segment list
  function automatic void push_run(input int extra0);
    rec_t r;
    if (cfg_cyc == 0) begin
      r = '{6, 0, 0, -1, -1, 1, 0}; q.push_back(r); return;
    end
    r = '{1, 0, 0, int'(PUMP_T), -1, 0, 0}; q.push_back(r);
    r = '{2, 0, 0, int'(STAB_T), -1, 0, 0}; q.push_back(r);
    for (int c = 0; c < cfg_cyc; c++)
      for (int k = 0; k < int'(N_CH); k++) begin
        r = '{3, k, c, cfg_pulse[k] + ((c == 0 && k == 0) ? extra0 : 0), cfg_pulse[k], 0, 0};
        q.push_back(r);
        r = '{4, k, c, cfg_gap, -1, 0, 0};       q.push_back(r);
        r = '{5, k, c, cfg_purge[k], -1, 0, 0};  q.push_back(r);
      end
    r = '{6, 0, cfg_cyc, -1, -1, 1, 0}; q.push_back(r);
  endfunction

  // Monitor: segment bookkeeping at every negedge
  int seg_ticks = 0, seg_open = 0, prev_st = 0;
  bit prev_tick = 1'b0, prev_valve = 1'b0;
  always @(negedge clk) begin : mon
    int s, v, vv, vp, ht, bz;
    s = int'(bus.state);
    chk("invariant", (($countones(bus.valve) <= 1) && !(|bus.valve && bus.vac_valve)) ? 1 : 0, 1);
    if (s != prev_st) begin
      if (!abort_seg && cur.dur >= 0)  chk($sformatf("st%0d.ticks", cur.st), seg_ticks, cur.dur);
      if (!abort_seg && cur.open >= 0) chk($sformatf("st%0d.open_ticks", cur.st), seg_open, cur.open);
      abort_seg = 1'b0;
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_state: got %0d expected no change (t=%0t)", s, $time);
      end else begin
        cur = q.pop_front();
        exp_out(cur.st, cur.ch, v, vv, vp, ht, bz);
        chk("state", s, cur.st);
        chk($sformatf("st%0d.ch_idx", cur.st), bus.ch_idx, cur.ch);
        chk($sformatf("st%0d.cycle_cnt", cur.st), bus.cycle_cnt, cur.cnt);
        chk($sformatf("st%0d.valve", cur.st), bus.valve, v);
        chk($sformatf("st%0d.vac_valve", cur.st), bus.vac_valve, vv);
        chk($sformatf("st%0d.vac_pump", cur.st), bus.vac_pump, vp);
        chk($sformatf("st%0d.heater", cur.st), bus.heater, ht);
        chk($sformatf("st%0d.busy", cur.st), bus.busy, bz);
        chk($sformatf("st%0d.done", cur.st), bus.done, cur.dn);
        chk($sformatf("st%0d.fault", cur.st), bus.fault, cur.ft);
      end
      seg_ticks = 0; seg_open = 0;
    end else begin
      if (prev_tick) seg_ticks++;
      if (prev_tick && prev_valve) seg_open++;
    end
    prev_st    = s;
    prev_tick  = bus.tick;
    prev_valve = |bus.valve;
  end

  task automatic cyc();     @(posedge clk); #1; endtask
  task automatic negsync(); @(negedge clk); #1; endtask

  task automatic drive_cfg();
    for (int k = 0; k < int'(N_CH); k++) begin
      bus.pulse_pre[k*TW +: TW] = TW'(cfg_pulse[k]);
      bus.purge_pre[k*TW +: TW] = TW'(cfg_purge[k]);
    end
    bus.gap_pre    = TW'(cfg_gap);
    bus.cycles_pre = CW'(cfg_cyc);
  endtask

  task automatic base_cfg();
    cfg_pulse[0] = 5; cfg_pulse[1] = 3;
    cfg_purge[0] = 6; cfg_purge[1] = 2;
    cfg_gap = 1; cfg_cyc = 2;
  endtask

  task automatic do_start(input int extra0);
    drive_cfg();
    cyc();
    bus.start = 1'b1;
    push_run(extra0);
    cyc();
    bus.start = 1'b0;
  endtask

  // Called just after a negedge so the monitor's current segment is settled
  task automatic do_stop();
    rec_t r;
    bus.stop  = 1'b1;
    abort_seg = 1'b1;
    q.delete();
    r = '{0, cur.ch, cur.cnt, -1, -1, cur.dn, cur.ft};
    q.push_back(r);
    cyc();
    bus.stop = 1'b0;
  endtask

  task automatic wait_for(input int st, input int ch, input int cnt, input string name);
    for (int i = 0; i < 4000; i++) begin
      negsync();
      if (int'(bus.state) == st && (ch < 0 || int'(bus.ch_idx) == ch) &&
          (cnt < 0 || int'(bus.cycle_cnt) == cnt)) return;
    end
    timeout(name);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 6000; i++) begin
      negsync();
      if (q.size() == 0 && int'(bus.state) == 6) return;
    end
    timeout(name);
  endtask

  task automatic wait_ticks(input int target, input string name);
    for (int i = 0; i < 200; i++) begin
      negsync();
      if (tick_edges >= target) return;
    end
    timeout(name);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rec_t r;
    int   base;
    rst = 1'b0;
    bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.temp_ok = 1'b1; bus.pressure_ok = 1'b1;
    base_cfg(); drive_cfg();
    cur = '{0, 0, 0, -1, -1, 0, 0};

    // Reset state
    repeat (3) negsync();
    chk("rst.state", bus.state, 0);
    chk("rst.valve", bus.valve, 0);
    chk("rst.vac_pump", bus.vac_pump, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.cycle_cnt", bus.cycle_cnt, 0);
    rst = 1'b1;
    repeat (3) cyc();

    // Full base run; presets scrambled mid-run must be ignored
    do_start(0);
    bus.pulse_pre = '1; bus.purge_pre = '0; bus.gap_pre = TW'(9); bus.cycles_pre = CW'(7);
    wait_done("base_run");
    chk("base.cycle_cnt", bus.cycle_cnt, cfg_cyc);
    chk("base.done", bus.done, 1);
    chk("base.busy", bus.busy, 0);

    // cycles_pre = 0 from IDLE: straight to DONE
    do_stop();
    cfg_cyc = 0;
    drive_cfg(); cyc();
    bus.start = 1'b1; push_run(0); cyc(); bus.start = 1'b0;
    chk("zero.state", bus.state, 6);
    chk("zero.done", bus.done, 1);
    chk("zero.valve", bus.valve, 0);
    repeat (3) negsync();
    do_stop();

    // Stop in PULSE of channel 1, cycle 0, then restart
    base_cfg();
    do_start(0);
    wait_for(3, 1, 0, "pulse_ch1");
    do_stop();
    chk("stop.state", bus.state, 0);
    chk("stop.valve", bus.valve, 0);
    chk("stop.vac_pump", bus.vac_pump, 0);
    do_start(0);
    wait_done("restart_run");
    chk("restart.cycle_cnt", bus.cycle_cnt, 2);

    // temp_ok lost for one tick in STAB after two good ticks, then lost in GAP
    do_start(0);
    wait_for(2, -1, -1, "stab");
    base = tick_edges;
    wait_ticks(base + 2, "stab_two_ticks");
    bus.temp_ok = 1'b0;
    cur.dur = 2 + 1 + int'(STAB_T);
    wait_ticks(base + 3, "stab_drop_tick");
    bus.temp_ok = 1'b1;
    wait_for(4, -1, -1, "gap");
    bus.temp_ok = 1'b0;
    abort_seg = 1'b1;
    q.delete();
    r = '{7, cur.ch, cur.cnt, -1, -1, 0, 1};
    q.push_back(r);
    cyc();
    chk("fault.state", bus.state, 7);
    chk("fault.fault", bus.fault, 1);
    chk("fault.vac_pump", bus.vac_pump, 1);
    bus.temp_ok = 1'b1;
    repeat (5) negsync();
    chk("fault.held", bus.state, 7);
    do_stop();
    chk("fault_stop.state", bus.state, 0);
    chk("fault_stop.fault", bus.fault, 1);

    // Asynchronous reset during PURGE
    do_start(0);
    wait_for(5, -1, -1, "purge");
    rst = 1'b0;
    abort_seg = 1'b1;
    q.delete();
    r = '{0, 0, 0, -1, -1, 0, 0};
    q.push_back(r);
    #1;
    chk("arst.vac_pump", bus.vac_pump, 0);
    chk("arst.vac_valve", bus.vac_valve, 0);
    chk("arst.heater", bus.heater, 0);
    chk("arst.busy", bus.busy, 0);
    chk("arst.state", bus.state, 0);
    repeat (3) negsync();
    rst = 1'b1;
    repeat (30) cyc();
    chk("arst.no_run", bus.state, 0);

`ifdef ALD_PRESSURE_INTERLOCK_EN
    // Pressure loss for two ticks in PULSE ch0: pulse stretches, open time holds
    do_start(2);
    wait_for(3, 0, 0, "p0");
    base = tick_edges;
    wait_ticks(base + 1, "p0_first_tick");
    bus.pressure_ok = 1'b0;
    wait_ticks(base + 3, "p0_frozen_ticks");
    bus.pressure_ok = 1'b1;
    wait_done("interlock_run");
    do_stop();
`endif

    // Randomised runs against the segment model
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        cfg_pulse[k] = int'($urandom_range(0, 6));
        cfg_purge[k] = int'($urandom_range(0, 6));
      end
      cfg_gap = int'($urandom_range(0, 3));
      cfg_cyc = int'($urandom_range(0, 3));
      if (cfg_cyc == 0 && cur.st == 6) do_stop();
      do_start(0);
      if ($urandom_range(0, 1) == 1) begin
        bus.pulse_pre = {$urandom, $urandom}; bus.gap_pre = $urandom;
      end
      wait_done($sformatf("rand_run%0d", n));
      chk($sformatf("rand%0d.cycle_cnt", n), bus.cycle_cnt, cfg_cyc);
    end

    repeat (4) negsync();
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ald_cycle_sequencer.md
Name: ald_cycle_sequencer

Overview:
- Parametrised atomic-layer-deposition cycle sequencer; successor to the fixed two-precursor ladder controller.
- Runs pump-down and thermal stabilisation, then N_CH precursor channels in order: pulse, gap, purge per channel, repeated cycles_pre times.
- All timing in ticks from the existing 1 kHz down-clock strobe; presets are runtime inputs, snapshotted at start.
- Sits between the board switch/sensor inputs and the valve/pump/heater LED-driven outputs.

Parameters:
N_CH, 2, number of precursor channels (>=1)
TW, 32, timer/preset width
CW, 16, cycle counter width
PUMP_T, 200, pump-down duration in ticks
STAB_T, 10000, required continuous temp_ok time in ticks before first pulse

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  asynchronous active-low reset
tick  input  1  one-clk strobe, 1 ms period
start  input  1  level; rising edge launches a run
stop  input  1  level; abort, highest priority
temp_ok  input  1  reactor temperature in range
pressure_ok  input  1  line pressure valid (used only with option)
pulse_pre  input  N_CH*TW  per-channel pulse ticks, channel k at [k*TW +: TW]
purge_pre  input  N_CH*TW  per-channel purge ticks, same packing
gap_pre  input  TW  ticks between valve close and purge open
cycles_pre  input  CW  number of full cycles
valve  output  N_CH  precursor valves, one-hot or zero
vac_valve  output  1  vacuum valve
vac_pump  output  1  vacuum pump
heater  output  1  reactor heater
busy  output  1  high in every state except IDLE/DONE
done  output  1  sticky run-complete flag
fault  output  1  sticky temperature fault
cycle_cnt  output  CW  completed cycles
ch_idx  output  max(1,$clog2(N_CH))  active channel
state  output  3  encoded state

Behaviour:
- Reset (async, rst=0): state=IDLE; all outputs 0; timer acc=0; config snapshot=0.
- Start edge: registered previous start value; edge = start & !prev. Edge honoured only in IDLE or DONE with stop=0.
- Timer: single TW-bit acc, cleared on every state entry. Increments on tick in timed states. Exit when acc >= preset, compared every clk. Preset 0 therefore gives a 1-clk state.
- Tick and expiry in the same clk: transition wins; acc cleared.
- Snapshot: pulse_pre, purge_pre, gap_pre, cycles_pre latched on an accepted start edge. Input changes mid-run are ignored.
- Start edge also sets cycle_cnt=0, ch_idx=0, done=0, fault=0.
- State encoding: IDLE=0, PUMP=1, STAB=2, PULSE=3, GAP=4, PURGE=5, DONE=6, FAULT=7.
- IDLE: all actuators off.
  - Accepted start with cycles_pre==0 -> DONE, done=1.
  - Accepted start otherwise -> PUMP.
- PUMP: vac_pump=1, vac_valve=1, heater=1. After PUMP_T ticks -> STAB.
- STAB: vac_pump=1, heater=1. acc counts ticks only while temp_ok=1; temp_ok=0 clears acc. acc>=STAB_T -> PULSE.
- PULSE: valve[ch_idx]=1, vac_pump=1, heater=1. After pulse_pre[ch_idx] -> GAP.
- GAP: valves closed, vac_pump=1, heater=1. After gap_pre -> PURGE.
- PURGE: vac_valve=1, vac_pump=1, heater=1. After purge_pre[ch_idx]:
  - ch_idx<N_CH-1: ch_idx+1, go to PULSE.
  - Otherwise cycle_cnt+1 and ch_idx=0. If the new cycle_cnt==cycles_pre -> DONE, else -> PULSE.
- DONE: done=1, vac_pump=1, all else off. Accepted start edge begins a new run.
- FAULT: entered when temp_ok=0 in PULSE, GAP or PURGE. fault=1, vac_pump=1, all else off. Leaves only via stop -> IDLE; fault stays 1 until the next start.
- Stop: stop=1 in any state -> IDLE on the next clk. All actuators 0 that clk. done/fault unchanged. Overrides simultaneous expiry or fault.
- Invariant: valve never has more than one bit set, and is never set together with vac_valve.
- cycle_cnt saturates at cycles_pre and never wraps.
- Output registration: all outputs registered, decoded from next-state, so actuators change in the same clk as the state.

Optional Feature:
- ALD_PRESSURE_INTERLOCK_EN defined: in PULSE, pressure_ok=0 forces valve to 0 and freezes acc (tick ignored). Pulse resumes when pressure_ok=1, so total valve-open ticks still equal pulse_pre.
- Macro undefined: pressure_ok ignored; it is not connected internally.

Test Plan:
- Base config (all tests): N_CH=2, PUMP_T=4, STAB_T=3, pulse={5,3}, gap=1, purge={6,2}, cycles_pre=2, tick every 4 clk, temp_ok=1.
- Start -> state sequence PUMP, STAB, then P0,G,U0,P1,G,U1 twice, then DONE. valve[0] high exactly 5 ticks per cycle; cycle_cnt=2; done=1; busy=0.
- cycles_pre=0, start -> DONE next clk, done=1, valve never set.
- stop pulsed mid-PULSE (ch 1, cycle 0) -> next clk state=IDLE, valve=0, vac_pump=0. A second start edge restarts with cycle_cnt=0.
- temp_ok dropped for 1 tick during STAB after acc=2 -> acc cleared, 3 further ticks needed. temp_ok dropped during GAP -> FAULT, fault=1, vac_pump=1; stop -> IDLE.
- rst asserted during PURGE -> outputs 0 immediately, without a clk edge. After release, no run without a new start edge.
- With ALD_PRESSURE_INTERLOCK_EN: pressure_ok low for 2 ticks in P0 -> valve drops, PULSE lasts 7 ticks, open time 5 ticks.
